// File: rtl/ddr_burst_responder_pkg.sv
// Shared definitions for the DDR burst responder and the data cache store handshake.
// The state codes are visible to the cache, so their values are fixed.
package ddr_burst_responder_pkg;

   localparam logic [3:0] MEM_WRITE_DATA_STORE = 4'd9;

   localparam int unsigned BURST_LEN_DEFAULT     = 16;
   localparam int unsigned JMP_BURST_LEN_DEFAULT = 2;

   typedef enum logic [3:0] {
      StIdle              = 4'd1,
      StMemReadData       = 4'd2,
      StMemReadJmp        = 4'd3,
      StReadEnd           = 4'd4,
      StWriteEnd          = 4'd5,
      StMemWriteDataStore = MEM_WRITE_DATA_STORE
   } state_e;

   typedef enum logic [1:0] {
      GrantNone,
      GrantStore,
      GrantJmp,
      GrantRead
   } grant_e;

   // Fixed priority: store > jump read > data read.
   function automatic grant_e arbitrate(input logic store, input logic jmp, input logic read);
      grant_e result;
      result = GrantNone;
      if (store) begin
         result = GrantStore;
      end else if (jmp) begin
         result = GrantJmp;
      end else if (read) begin
         result = GrantRead;
      end
      return result;
   endfunction

endpackage

// File: rtl/ddr_burst_responder_burst_beat_counter.sv
// Beat counter with synchronous load and saturating increment; load wins over increment.
module burst_beat_counter #(
   parameter int unsigned CNT_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_value,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (inc && (count_q != CntMax)) begin
         count_d = count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ddr_burst_responder.sv
// DDR-side responder for the data cache: arbitrates cache requests, issues fixed-length bursts
// to the DDR burst controller, returns read beats and streams store data.
module ddr_burst_responder
   import ddr_burst_responder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned DDR_ADDR_WIDTH = 28,
   parameter int unsigned BURST_LEN      = BURST_LEN_DEFAULT,
   parameter int unsigned JMP_BURST_LEN  = JMP_BURST_LEN_DEFAULT,
   parameter int unsigned CNT_WIDTH      = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      data_read_req,
   input  logic                      data_store_req,
   input  logic                      jmp_addr_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
   input  logic [DDR_ADDR_WIDTH-1:0] data_write_addr,
   input  logic [DATA_WIDTH-1:0]     data_to_ddr,
   input  logic                      data_to_ddr_rdy,
   output logic [DATA_WIDTH-1:0]     data_to_cache,
   output logic [DDR_ADDR_WIDTH-1:0] jmp_addr_to_cache,
   output logic [CNT_WIDTH-1:0]      rd_cnt_data,
   output logic                      rd_burst_data_valid,
   output logic                      wr_burst_data_req,
   output logic [3:0]                state_interface_module,
   output logic                      rd_burst_req,
   output logic                      wr_burst_req,
   output logic [CNT_WIDTH-1:0]      rd_burst_len,
   output logic [CNT_WIDTH-1:0]      wr_burst_len,
   output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
   output logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
   input  logic                      rd_burst_data_valid_mem,
   input  logic [DATA_WIDTH-1:0]     rd_burst_data_mem,
   input  logic                      wr_burst_data_req_mem,
   output logic [DATA_WIDTH-1:0]     wr_burst_data,
   input  logic                      rd_burst_finish,
   input  logic                      wr_burst_finish
);

   localparam logic [CNT_WIDTH-1:0] DataLen = CNT_WIDTH'(BURST_LEN);
   localparam logic [CNT_WIDTH-1:0] JmpLen  = CNT_WIDTH'(JMP_BURST_LEN);
   localparam int unsigned          JmpHiW  = DDR_ADDR_WIDTH - DATA_WIDTH;

   state_e                    state_q, state_d;
   grant_e                    grant_q, grant_d;
   grant_e                    idle_grant;
   logic                      rd_req_q, rd_req_d;
   logic                      wr_req_q, wr_req_d;
   logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DDR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [CNT_WIDTH-1:0]      rd_len_q, rd_len_d;
   logic [CNT_WIDTH-1:0]      wr_len_q, wr_len_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic [DDR_ADDR_WIDTH-1:0] jmp_q, jmp_d;

   logic                      rd_cnt_load, rd_cnt_inc;
   logic                      wr_cnt_load, wr_cnt_inc;
   logic [CNT_WIDTH-1:0]      rd_cnt;
   logic [CNT_WIDTH-1:0]      wr_cnt;
   logic                      granted_level;

   logic                      rd_valid_out;
   logic                      wr_req_out;
   logic [DATA_WIDTH-1:0]     wr_data_out;

   assign idle_grant = arbitrate(data_store_req, jmp_addr_read_req, data_read_req);

   always_comb begin
      unique case (grant_q)
         GrantStore: granted_level = data_store_req;
         GrantJmp:   granted_level = jmp_addr_read_req;
         GrantRead:  granted_level = data_read_req;
         GrantNone:  granted_level = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rd_req_d     = rd_req_q;
      wr_req_d     = wr_req_q;
      rd_addr_d    = rd_addr_q;
      wr_addr_d    = wr_addr_q;
      rd_len_d     = rd_len_q;
      wr_len_d     = wr_len_q;
      data_d       = data_q;
      jmp_d        = jmp_q;
      rd_cnt_load  = 1'b0;
      rd_cnt_inc   = 1'b0;
      wr_cnt_load  = 1'b0;
      wr_cnt_inc   = 1'b0;
      rd_valid_out = 1'b0;
      wr_req_out   = 1'b0;
      wr_data_out  = '0;

      unique case (state_q)
         StIdle: begin
            grant_d = idle_grant;
            unique case (idle_grant)
               GrantStore: begin
                  state_d     = StMemWriteDataStore;
                  wr_req_d    = 1'b1;
                  wr_addr_d   = data_write_addr;
                  wr_len_d    = DataLen;
                  wr_cnt_load = 1'b1;
               end
               GrantJmp: begin
                  state_d     = StMemReadJmp;
                  rd_req_d    = 1'b1;
                  rd_addr_d   = data_read_addr;
                  rd_len_d    = JmpLen;
                  rd_cnt_load = 1'b1;
               end
               GrantRead: begin
                  state_d     = StMemReadData;
                  rd_req_d    = 1'b1;
                  rd_addr_d   = data_read_addr;
                  rd_len_d    = DataLen;
                  rd_cnt_load = 1'b1;
               end
               GrantNone: ;
            endcase
         end

         StMemReadData, StMemReadJmp: begin
            rd_valid_out = rd_burst_data_valid_mem;
            if (rd_burst_data_valid_mem) begin
               data_d     = rd_burst_data_mem;
               rd_cnt_inc = 1'b1;
               // The 1-based count doubles as the index of the beat now arriving.
               if (state_q == StMemReadJmp) begin
                  if (rd_cnt == CNT_WIDTH'(1)) begin
                     jmp_d[DATA_WIDTH-1:0] = rd_burst_data_mem;
                  end else if (rd_cnt == CNT_WIDTH'(2)) begin
                     jmp_d[DDR_ADDR_WIDTH-1:DATA_WIDTH] = rd_burst_data_mem[JmpHiW-1:0];
                  end
               end
            end
            if (rd_burst_finish) begin
               rd_req_d = 1'b0;
               state_d  = StReadEnd;
            end
         end

         StMemWriteDataStore: begin
            wr_cnt_inc  = wr_burst_data_req_mem;
            wr_req_out  = wr_burst_data_req_mem && (wr_cnt < DataLen);
            wr_data_out = data_to_ddr_rdy ? data_to_ddr : '0;
            if (wr_burst_finish) begin
               wr_req_d = 1'b0;
               state_d  = StWriteEnd;
            end
         end

         StReadEnd, StWriteEnd: begin
            // Wait for the served level request to drop so it is not granted twice.
            if (!granted_level) begin
               state_d = StIdle;
               grant_d = GrantNone;
            end
         end

         default: begin
            state_d = StIdle;
            grant_d = GrantNone;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         grant_q   <= GrantNone;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         rd_len_q  <= '0;
         wr_len_q  <= '0;
         data_q    <= '0;
         jmp_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         rd_len_q  <= rd_len_d;
         wr_len_q  <= wr_len_d;
         data_q    <= data_d;
         jmp_q     <= jmp_d;
      end
   end

   burst_beat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_rd_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (rd_cnt_load),
      .load_value (CNT_WIDTH'(1)),
      .inc        (rd_cnt_inc),
      .count      (rd_cnt)
   );

   burst_beat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_wr_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (wr_cnt_load),
      .load_value ('0),
      .inc        (wr_cnt_inc),
      .count      (wr_cnt)
   );

   assign data_to_cache          = data_q;
   assign jmp_addr_to_cache      = jmp_q;
   assign rd_cnt_data            = rd_cnt;
   assign rd_burst_data_valid    = rd_valid_out;
   assign wr_burst_data_req      = wr_req_out;
   assign wr_burst_data          = wr_data_out;
   assign state_interface_module = state_q;
   assign rd_burst_req           = rd_req_q;
   assign wr_burst_req           = wr_req_q;
   assign rd_burst_len           = rd_len_q;
   assign wr_burst_len           = wr_len_q;
   assign rd_burst_addr          = rd_addr_q;
   assign wr_burst_addr          = wr_addr_q;

endmodule
